// File: rtl/alu_pkg.sv
// Shared ALU constants: opcodes, sequencer state encoding and an
// opcode-legality helper imported by the ALU, control unit and sequencer.
package alu_pkg;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_SHR = 5'b00101;
  localparam logic [4:0] OP_SHL = 5'b00110;
  localparam logic [4:0] OP_ROR = 5'b00111;
  localparam logic [4:0] OP_ROL = 5'b01000;
  localparam logic [4:0] OP_AND = 5'b01001;
  localparam logic [4:0] OP_OR  = 5'b01010;
  localparam logic [4:0] OP_MUL = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111;
  localparam logic [4:0] OP_NEG = 5'b10000;
  localparam logic [4:0] OP_NOT = 5'b10001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic op_legal(input logic [4:0] op);
    logic ok;
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR,
      OP_MUL, OP_DIV, OP_NEG, OP_NOT: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_seq_latency.sv
// Opcode -> execute latency decode. Ports: op in; lat_m1 = L-1 for the
// latency counter; illegal flags opcodes the ALU does not implement.
module alu_seq_latency
  import alu_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8,
  parameter int CW         = 4
) (
  input  logic [4:0]    op,
  output logic [CW-1:0] lat_m1,
  output logic          illegal
);

  always_comb begin
    lat_m1  = '0;
    illegal = !op_legal(op);
    if (op == OP_MUL) begin
      lat_m1 = CW'(MUL_CYCLES - 1);
    end else if (op == OP_DIV) begin
      lat_m1 = CW'(DIV_CYCLES - 1);
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU controller: latches op/operands on start, holds the ALU for
// an opcode-dependent latency, then captures the 64-bit result into hi/lo.
// Ports: clock, clear (async active-high); start/op/ra/rb request;
// alu_opcode/alu_ra/alu_rb to ALU; alu_zhi/alu_zlo from ALU;
// hi/lo result, busy, done pulse, err.
// Optional macro ALU_SEQ_DIV0_TRAP_EN: trap divide-by-zero in one cycle
// with hi=0, lo=all-ones, err=1.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [4:0]  op,
  input  logic [31:0] ra,
  input  logic [31:0] rb,
  output logic [4:0]  alu_opcode,
  output logic [31:0] alu_ra,
  output logic [31:0] alu_rb,
  input  logic [31:0] alu_zhi,
  input  logic [31:0] alu_zlo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    op_q, op_d;
  logic [31:0]   ra_q, ra_d;
  logic [31:0]   rb_q, rb_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          ill_q, ill_d;
`ifdef ALU_SEQ_DIV0_TRAP_EN
  logic          trap_q, trap_d;
`endif

  logic [CW-1:0] lat_m1;
  logic          illegal;

  alu_seq_latency #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CW         (CW)
  ) u_lat (
    .op      (op),
    .lat_m1  (lat_m1),
    .illegal (illegal)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    ill_d   = ill_q;
`ifdef ALU_SEQ_DIV0_TRAP_EN
    trap_d  = trap_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op;
          ra_d    = ra;
          rb_d    = rb;
          cnt_d   = lat_m1;
          ill_d   = illegal;
          busy_d  = 1'b1;
          state_d = ST_EXEC;
`ifdef ALU_SEQ_DIV0_TRAP_EN
          trap_d  = (op == OP_DIV) && (rb == 32'd0);
          if (trap_d) cnt_d = '0;
`endif
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          // Unknown opcodes leave stale ALU outputs, so force zero.
          if (ill_q) begin
            hi_d  = '0;
            lo_d  = '0;
            err_d = 1'b1;
`ifdef ALU_SEQ_DIV0_TRAP_EN
          end else if (trap_q) begin
            hi_d  = '0;
            lo_d  = '1;
            err_d = 1'b1;
`endif
          end else begin
            hi_d  = alu_zhi;
            lo_d  = alu_zlo;
            err_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ill_q   <= 1'b0;
`ifdef ALU_SEQ_DIV0_TRAP_EN
      trap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ill_q   <= ill_d;
`ifdef ALU_SEQ_DIV0_TRAP_EN
      trap_q  <= trap_d;
`endif
    end
  end

  assign alu_opcode = op_q;
  assign alu_ra     = ra_q;
  assign alu_rb     = rb_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU model.
// Honours ALU_SEQ_DIV0_TRAP_EN for the divide-by-zero expectations.
module tb_alu_sequencer;

  localparam int MUL_C = 4;
  localparam int DIV_C = 8;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [4:0]  op;
  logic [31:0] ra, rb;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_ra, alu_rb;
  logic [31:0] zhi, zlo;
  logic [31:0] hi, lo;
  logic        busy, done, err;

  alu_sequencer #(
    .MUL_CYCLES (MUL_C),
    .DIV_CYCLES (DIV_C)
  ) dut (
    .clock      (clock),
    .clear      (clear),
    .start      (start),
    .op         (op),
    .ra         (ra),
    .rb         (rb),
    .alu_opcode (alu_opcode),
    .alu_ra     (alu_ra),
    .alu_rb     (alu_rb),
    .alu_zhi    (zhi),
    .alu_zlo    (zlo),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clock = ~clock;

  always_comb begin
    zhi = '0;
    zlo = '0;
    case (alu_opcode)
      5'b00011: zlo = alu_ra + alu_rb;
      5'b00100: zlo = alu_ra - alu_rb;
      5'b01110: {zhi, zlo} = 64'(alu_ra) * 64'(alu_rb);
      5'b01111: begin
        if (alu_rb != 0) begin
          zlo = alu_ra / alu_rb;
          zhi = alu_ra % alu_rb;
        end else begin
          zhi = alu_ra;
          zlo = 32'hDEADBEEF;
        end
      end
      default: begin
        zhi = 32'hBAD0BAD0;
        zlo = 32'hBAD0BAD0;
      end
    endcase
  end

  typedef struct {
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got=1 want=0 (cyc %0d)", cyc);
      end else begin
        me = q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(me.cyc));
        chk("hi", 64'(hi), 64'(me.hi));
        chk("lo", 64'(lo), 64'(me.lo));
        chk("err", 64'(err), 64'(me.err));
        chk("busy_in_done", 64'(busy), 64'd1);
      end
    end
  end

  // Called just after a negedge; start is sampled on the next posedge,
  // which becomes cycle 0. Returns at the negedge inside cycle 1.
  task automatic issue(input logic [4:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int lat,
                       input logic [31:0] eh, input logic [31:0] el,
                       input logic ee);
    exp_t e;
    start = 1'b1;
    op    = o;
    ra    = a;
    rb    = b;
    e.cyc = cyc + 1 + lat;
    e.hi  = eh;
    e.lo  = el;
    e.err = ee;
    q.push_back(e);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clock);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got=%0d want=0 pending", q.size());
      q.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b1;
    start = 1'b0;
    op    = '0;
    ra    = '0;
    rb    = '0;
    repeat (2) @(negedge clock);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_alu_op", 64'(alu_opcode), 64'd0);
    clear = 1'b0;
    @(negedge clock);

    // add
    issue(5'b00011, 32'd5, 32'd7, 1, 32'd0, 32'd12, 1'b0);
    chk("add_busy_c1", 64'(busy), 64'd1);
    @(negedge clock);
    chk("add_busy_c2", 64'(busy), 64'd1);
    @(negedge clock);
    chk("add_busy_c3", 64'(busy), 64'd0);
    drain();

    // multiply, inputs wiggled to prove the ALU operands are held
    issue(5'b01110, 32'h00010000, 32'h00010000, MUL_C,
          32'd1, 32'd0, 1'b0);
    ra = 32'hFFFFFFFF;
    rb = 32'h12345678;
    op = 5'b00011;
    for (int i = 0; i < MUL_C; i++) begin
      chk("mul_alu_ra", 64'(alu_ra), 64'h00010000);
      chk("mul_alu_rb", 64'(alu_rb), 64'h00010000);
      chk("mul_alu_op", 64'(alu_opcode), 64'b01110);
      chk("mul_busy", 64'(busy), 64'd1);
      @(negedge clock);
    end
    drain();

    // divide with an ignored start while busy
    issue(5'b01111, 32'd17, 32'd5, DIV_C, 32'd2, 32'd3, 1'b0);
    @(negedge clock);
    @(negedge clock);
    start = 1'b1;
    op    = 5'b00011;
    ra    = 32'd100;
    rb    = 32'd100;
    @(negedge clock);
    start = 1'b0;
    drain();
    repeat (4) @(negedge clock);

    // clear mid-divide
    issue(5'b01111, 32'd100, 32'd7, DIV_C, 32'd2, 32'd14, 1'b0);
    repeat (3) @(negedge clock);
    clear = 1'b1;
    #1;
    chk("clr_hi", 64'(hi), 64'd0);
    chk("clr_lo", 64'(lo), 64'd0);
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_done", 64'(done), 64'd0);
    chk("clr_err", 64'(err), 64'd0);
    chk("clr_alu_ra", 64'(alu_ra), 64'd0);
    q.delete();
    @(negedge clock);
    clear = 1'b0;
    repeat (DIV_C + 4) @(negedge clock);
    chk("clr_no_done_lo", 64'(lo), 64'd0);
    issue(5'b00011, 32'd1, 32'd1, 1, 32'd0, 32'd2, 1'b0);
    drain();

    // divide by zero
`ifdef ALU_SEQ_DIV0_TRAP_EN
    issue(5'b01111, 32'd9, 32'd0, 1, 32'd0, 32'hFFFFFFFF, 1'b1);
`else
    issue(5'b01111, 32'd9, 32'd0, DIV_C, 32'd9, 32'hDEADBEEF, 1'b0);
`endif
    drain();

    // illegal opcode, then a legal one clears err
    issue(5'b11111, 32'd3, 32'd4, 1, 32'd0, 32'd0, 1'b1);
    drain();
    chk("ill_err_hold", 64'(err), 64'd1);
    issue(5'b00100, 32'd10, 32'd3, 1, 32'd0, 32'd7, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
